program_loader: RTL and testbench

Byte-serial writer that fills the instruction/data memory read by the CPU's fetch states, then releases the CPU to run.
- Accepts a framed program image on a valid/ready byte stream and writes each payload byte to consecutive memory addresses.
- Verifies a trailing checksum, then deasserts the CPU's active-low reset.
- Sits between the host/UART byte source and the memory write port, ahead of control_state_machine.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_checksum.sv | 30 +++
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and frame constants for the program loader.
// The state enum is common to the loader top and any block that observes it.
package loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_LOAD,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

  localparam int BYTE_WIDTH = 8;
  localparam int LEN_WIDTH  = 16;

  localparam logic [BYTE_WIDTH-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit wrapping payload accumulator.
// o_zero reports whether the candidate check byte on i_data brings the running sum to zero.
module loader_checksum
  import loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_add_en,
  input  logic [BYTE_WIDTH-1:0] i_data,
  output logic                  o_zero
);

  logic [BYTE_WIDTH-1:0] r_sum;
  logic [BYTE_WIDTH-1:0] w_total;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign w_total = r_sum + i_data;
  assign o_zero  = (w_total == '0);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/LEN/payload/CHK frames, writes payload to
// program memory and releases the CPU reset once the checksum passes.
module program_loader
  import loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

  ld_state_t r_state;
  ld_state_t w_state_next;

  logic [BYTE_WIDTH-1:0] r_len_lo;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [BYTE_WIDTH-1:0] r_mem_wdata;

  logic                 w_accept;
  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_len_too_big;
  logic                 w_chk_ok;

  assign w_accept      = in_valid && in_ready;
  assign w_len         = {in_data, r_len_lo};
  assign w_len_too_big = ({1'b0, w_len} > MAX_LEN);

  loader_checksum u_checksum (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_accept && (r_state == LD_LEN_HI)),
    .i_add_en (w_accept && (r_state == LD_LOAD)),
    .i_data   (in_data),
    .o_zero   (w_chk_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LD_IDLE:   if (w_accept && (in_data == SYNC_BYTE)) w_state_next = LD_LEN_LO;
      LD_LEN_LO: if (w_accept) w_state_next = LD_LEN_HI;
      LD_LEN_HI: begin
        if (w_accept) begin
          if (w_len_too_big)      w_state_next = LD_ERROR;
          else if (w_len == '0)   w_state_next = LD_CHECK;
          else                    w_state_next = LD_LOAD;
        end
      end
      LD_LOAD:   if (w_accept && (r_remaining == LEN_WIDTH'(1))) w_state_next = LD_CHECK;
      LD_CHECK:  if (w_accept) w_state_next = w_chk_ok ? LD_DONE : LD_ERROR;
      LD_DONE:   if (w_accept && (in_data == SYNC_BYTE)) w_state_next = LD_LEN_LO;
      LD_ERROR:  w_state_next = LD_ERROR;
      default:   w_state_next = LD_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = !reset && (r_state != LD_ERROR);
    cpu_reset_n = (r_state == LD_DONE);
    load_done   = (r_state == LD_DONE);
    load_error  = (r_state == LD_ERROR);
    mem_we      = r_mem_we;
    mem_addr    = r_mem_addr;
    mem_wdata   = r_mem_wdata;
  end

  // Write strobe is registered: each accepted payload byte yields exactly one pulse next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len_lo    <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          LD_LEN_LO: r_len_lo <= in_data;
          LD_LEN_HI: begin
            r_remaining <= w_len;
            r_addr      <= '0;
          end
          LD_LOAD: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= in_data;
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: a frame-level model predicts every output each cycle,
// plus literal checks on the directed frames.
module tb_program_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset_n;
  logic       load_done;
  logic       load_error;

  program_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: position within frame, bytes written, running sum.
  int         m_pos = -1;
  int         m_len = 0;
  int         m_written = 0;
  logic [7:0] m_len_lo = 0;
  logic [7:0] m_sum = 0;
  bit         m_done = 0;
  bit         m_error = 0;
  bit         e_we = 0;
  int         e_addr = 0;
  logic [7:0] e_wdata = 0;

  always @(posedge clock) begin
    bit acc;
    acc  = in_valid && !reset && !m_error;
    e_we = 0;
    if (reset) begin
      m_pos = -1; m_done = 0; m_error = 0;
    end else if (acc) begin
      if (m_pos < 0) begin
        if (in_data == 8'hA5) begin m_pos = 1; m_done = 0; end
      end else if (m_pos == 1) begin
        m_len_lo = in_data; m_pos = 2;
      end else if (m_pos == 2) begin
        m_len = int'(in_data) * 256 + int'(m_len_lo);
        if (m_len > 256) m_error = 1;
        else begin m_pos = 3; m_sum = 0; m_written = 0; end
      end else if (m_written < m_len) begin
        e_we = 1; e_addr = m_written; e_wdata = in_data;
        m_sum = m_sum + in_data;
        m_written++;
      end else begin
        if (8'(m_sum + in_data) == 8'h00) begin m_done = 1; m_pos = -1; end
        else m_error = 1;
      end
    end
  end

  logic [15:0] wlog[$];

  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready", in_ready, !reset && !m_error);
      check("mem_we", mem_we, e_we);
      check("cpu_reset_n", cpu_reset_n, m_done);
      check("load_done", load_done, m_done);
      check("load_error", load_error, m_error);
      if (e_we) begin
        check("mem_addr", mem_addr, e_addr[7:0]);
        check("mem_wdata", mem_wdata, e_wdata);
      end
      if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      in_data = 8'($urandom);
      @(posedge clock); #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic rdy;
    in_data  = b;
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); rdy = in_ready;
      @(posedge clock); #1;
      if (rdy) break;
    end
    in_valid = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1; in_valid = 0;
    repeat (n) begin @(posedge clock); #1; end
    reset = 0;
    @(negedge clock);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    @(posedge clock); #1;
  endtask

  task automatic send_frame(input int len, input bit bad, input int gap_pct);
    logic [7:0] sum, b;
    sum = 0;
    send(8'hA5);
    send(8'(len));
    send(8'(len >> 8));
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(99, 0) < gap_pct) idle($urandom_range(2, 1));
      b = 8'($urandom);
      sum = sum + b;
      send(b);
    end
    send(8'(8'h00 - sum) + (bad ? 8'h01 : 8'h00));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] junk;
    reset = 1; in_valid = 0; in_data = 0;
    @(posedge clock); #1;
    chk_en = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check("init_mem_addr", mem_addr, 0);
    check("init_mem_wdata", mem_wdata, 0);
    @(posedge clock); #1;

    // Junk, then a good 3-byte frame back-to-back.
    wlog.delete();
    send(8'h00); send(8'hFF);
    send(8'hA5); send(8'h03); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h9A);
    idle(2);
    check("A_nwrites", wlog.size(), 3);
    check("A_w0", wlog[0], 16'h0011);
    check("A_w1", wlog[1], 16'h0122);
    check("A_w2", wlog[2], 16'h0233);
    check("A_done", load_done, 1);
    check("A_cpu_run", cpu_reset_n, 1);
    check("A_model_done", m_done, 1);

    // Reload while running.
    wlog.delete();
    send(8'hA5);
    @(negedge clock);
    check("R_cpu_held", cpu_reset_n, 0);
    @(posedge clock); #1;
    send(8'h02); send(8'h00); send(8'hAA); send(8'h55); send(8'h01);
    idle(2);
    check("R_nwrites", wlog.size(), 2);
    check("R_w0", wlog[0], 16'h00AA);
    check("R_w1", wlog[1], 16'h0155);
    check("R_cpu_run", cpu_reset_n, 1);

    // Bad checksum.
    do_reset(1);
    wlog.delete();
    send(8'hA5); send(8'h03); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h9B);
    idle(3);
    check("B_nwrites", wlog.size(), 3);
    check("B_error", load_error, 1);
    check("B_cpu_held", cpu_reset_n, 0);
    check("B_ready_low", in_ready, 0);
    check("B_model_err", m_error, 1);

    // Zero length with leading junk.
    do_reset(1);
    wlog.delete();
    send(8'h00); send(8'hFF);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check("Z_nwrites", wlog.size(), 0);
    check("Z_done", load_done, 1);

    // Oversize length 0x0101.
    do_reset(1);
    wlog.delete();
    send(8'hA5); send(8'h01); send(8'h01);
    idle(2);
    check("O_error", load_error, 1);
    check("O_nwrites", wlog.size(), 0);

    // Full 256-byte image with valid gaps.
    do_reset(2);
    wlog.delete();
    send_frame(256, 0, 25);
    idle(2);
    check("F_nwrites", wlog.size(), 256);
    check("F_last_addr", wlog[255][15:8], 8'hFF);
    check("F_done", load_done, 1);

    // Reset mid-payload, then a fresh frame starts from address 0.
    do_reset(1);
    send(8'hA5); send(8'h0A); send(8'h00);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    do_reset(1);
    wlog.delete();
    send_frame(5, 0, 30);
    idle(2);
    check("M_nwrites", wlog.size(), 5);
    check("M_first_addr", wlog[0][15:8], 8'h00);
    check("M_done", load_done, 1);

    // Random frames, junk, oversize lengths and occasional resets.
    for (int f = 0; f < 30; f++) begin
      if (m_error || $urandom_range(7, 0) == 0) do_reset($urandom_range(2, 1));
      for (int j = $urandom_range(2, 0); j > 0; j--) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send(junk);
      end
      if ($urandom_range(9, 0) == 0) begin
        send(8'hA5); send(8'($urandom_range(255, 1))); send(8'h01);
      end else begin
        send_frame($urandom_range(40, 0), $urandom_range(3, 0) == 0, 30);
      end
      idle($urandom_range(3, 0));
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
